// File: rtl/eth_frame_detector_mem_responder_pkg.sv
// Shared constants and helpers for the pattern-memory responder.
// The matcher's scan port always wins the RAM; the host only gets idle cycles.
package eth_frame_detector_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 11;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Reads only need a free RAM port. Writes must also wait for a frame
    // boundary, so a pattern never changes under the matcher.
    function automatic logic host_grant(input logic req, input logic we,
                                        input logic scan_en, input logic scan_active);
        return req & ~scan_en & (~we | ~scan_active);
    endfunction

endpackage

// File: rtl/eth_frame_detector_mem_responder_if.sv
// Host request/acknowledge bus between the detector AXI block (master)
// and one pattern-memory responder (slave).
interface eth_frame_detector_mem_responder_if
    import eth_frame_detector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/eth_frame_detector_mem_responder_sp_ram.sv
// Inferred single-port pattern RAM. Writes are write-first, and reads have
// one registered cycle of latency. The contents are not reset.
module eth_frame_detector_sp_ram
    import eth_frame_detector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (en && we) mem[addr] <= wdata;
    end

    // The output register clears on reset, so the read ports come up at zero.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (en) rdata <= we ? wdata : mem[addr];
    end
endmodule

// File: rtl/eth_frame_detector_mem_responder.sv
// Pattern-memory responder: it arbitrates one single-port RAM between the
// matcher scan port (absolute priority) and the host, deferring host writes to frame gaps.
module eth_frame_detector_mem_responder
    import eth_frame_detector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    eth_frame_detector_mem_responder_if.slave    mem,
    input  logic                                 scan_active,
    input  logic                                 scan_en,
    input  logic [ADDR_WIDTH-1:0]                scan_addr,
    output logic [DATA_WIDTH-1:0]                scan_rdata,
    output logic                                 host_pending
);
    state_t                state, state_nxt;
    logic                  grant, issue;
    logic                  rd_q;
    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] host_rdata, host_hold;
    logic [DATA_WIDTH-1:0] scan_hold;
    logic [1:0]            scan_vld_pipe;

    assign grant = host_grant(mem.mem_req, mem.mem_we, scan_en, scan_active);
    assign issue = ((state == ST_IDLE) || (state == ST_WAIT)) && grant;

    // The host drives the RAM only when scan_en is low, so the port mux never collides.
    assign ram_en   = scan_en | issue;
    assign ram_we   = issue & mem.mem_we & ~rst;
    assign ram_addr = scan_en ? scan_addr : mem.mem_addr;

    eth_frame_detector_sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem.mem_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_WAIT: begin
                if (issue)            state_nxt = ST_RESP;
                else if (mem.mem_req) state_nxt = ST_WAIT;
                else                  state_nxt = ST_IDLE;
            end
            ST_RESP:                  state_nxt = ST_DONE;
            // The requester may still hold req right after ack, so wait for it to drop.
            ST_DONE: if (!mem.mem_req) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            rd_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) rd_q <= ~mem.mem_we;
        end
    end

    // Read data appears with ack straight from the RAM register and is held afterwards.
    assign host_rdata = ((state == ST_RESP) && rd_q && !rst) ? ram_rdata : host_hold;

    assign scan_vld_pipe[0] = scan_en;
    assign scan_rdata       = scan_vld_pipe[1] ? ram_rdata : scan_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            host_hold        <= '0;
            scan_hold        <= '0;
            scan_vld_pipe[1] <= 1'b0;
        end else begin
            host_hold        <= host_rdata;
            scan_hold        <= scan_rdata;
            scan_vld_pipe[1] <= scan_vld_pipe[0];
        end
    end

    assign mem.mem_ack   = (state == ST_RESP) && !rst;
    assign mem.mem_rdata = host_rdata;
    assign host_pending  = (state == ST_WAIT) && !rst;
endmodule

// File: tb/tb_eth_frame_detector_mem_responder.sv
// Directed bench for the pattern-memory responder. One 64-bit and one 128-bit
// instance share the stimulus, and both are checked against a transaction-level model.
module tb_eth_frame_detector_mem_responder;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [AW-1:0] addr;
    logic [127:0]  wdata;
    logic          scan_active, scan_en;
    logic [AW-1:0] scan_addr;
    logic [63:0]   scan_rdata64;
    logic [127:0]  scan_rdata128;
    logic          pend64, pend128;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    eth_frame_detector_mem_responder_if #(.DATA_WIDTH(64),  .ADDR_WIDTH(AW)) m64 ();
    eth_frame_detector_mem_responder_if #(.DATA_WIDTH(128), .ADDR_WIDTH(AW)) m128 ();

    assign m64.mem_req    = req;
    assign m64.mem_we     = we;
    assign m64.mem_addr   = addr;
    assign m64.mem_wdata  = wdata[63:0];
    assign m128.mem_req   = req;
    assign m128.mem_we    = we;
    assign m128.mem_addr  = addr;
    assign m128.mem_wdata = wdata;

    eth_frame_detector_mem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(AW)) u64 (
        .clk (clk), .rst (rst), .mem (m64),
        .scan_active (scan_active), .scan_en (scan_en), .scan_addr (scan_addr),
        .scan_rdata (scan_rdata64), .host_pending (pend64)
    );

    eth_frame_detector_mem_responder #(.DATA_WIDTH(128), .ADDR_WIDTH(AW)) u128 (
        .clk (clk), .rst (rst), .mem (m128),
        .scan_active (scan_active), .scan_en (scan_en), .scan_addr (scan_addr),
        .scan_rdata (scan_rdata128), .host_pending (pend128)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Transaction model: the memory is an associative array. Each access
    // completes one cycle after the first cycle it is allowed, and the next
    // one needs req to drop after the ack.
    logic [127:0] mram [int];
    bit           e_ack, e_pend, e_rel, e_rd_known, e_scan_v;
    logic [127:0] e_rdata, e_scan;

    always @(posedge clk) begin
        if (rst) begin
            e_ack = 0; e_pend = 0; e_rel = 0; e_scan_v = 0;
            e_rdata = '0; e_rd_known = 1;
        end else begin
            e_scan_v = scan_en && mram.exists(int'(scan_addr));
            if (e_scan_v) e_scan = mram[int'(scan_addr)];
            e_pend = 0;
            if (e_ack) begin
                e_ack = 0; e_rel = 1;
            end else if (e_rel) begin
                if (!req) e_rel = 0;
            end else if (req && !scan_en && (!we || !scan_active)) begin
                if (we) mram[int'(addr)] = wdata;
                else begin
                    e_rd_known = mram.exists(int'(addr));
                    if (e_rd_known) e_rdata = mram[int'(addr)];
                end
                e_ack = 1;
            end else begin
                e_pend = req;
            end
        end
    end

    always @(negedge clk) begin
        if (m128.mem_ack) ack_cnt++;
        if (run) begin
            if (rst) begin
                chk("rst_ack64", {127'b0, m64.mem_ack}, 0);
                chk("rst_ack128", {127'b0, m128.mem_ack}, 0);
                chk("rst_pend64", {127'b0, pend64}, 0);
                chk("rst_pend128", {127'b0, pend128}, 0);
            end else begin
                chk("ack64", {127'b0, m64.mem_ack}, {127'b0, e_ack});
                chk("ack128", {127'b0, m128.mem_ack}, {127'b0, e_ack});
                chk("pend64", {127'b0, pend64}, {127'b0, e_pend});
                chk("pend128", {127'b0, pend128}, {127'b0, e_pend});
                if (e_rd_known) begin
                    chk("rdata64", {64'b0, m64.mem_rdata}, {64'b0, e_rdata[63:0]});
                    chk("rdata128", m128.mem_rdata, e_rdata);
                end
                if (e_scan_v) begin
                    chk("scan64", {64'b0, scan_rdata64}, {64'b0, e_scan[63:0]});
                    chk("scan128", scan_rdata128, e_scan);
                end
            end
        end
    end

    int           lat;
    logic [127:0] r64, r128;
    int           c0;

    task automatic host_access(input bit w, input logic [AW-1:0] a, input logic [127:0] d,
                               input int hold, output int l,
                               output logic [127:0] o64, output logic [127:0] o128);
        @(posedge clk); #1;
        req = 1; we = w; addr = a; wdata = d;
        l = -1; o64 = '0; o128 = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m128.mem_ack) begin
                l = i; o64 = {64'b0, m64.mem_rdata}; o128 = m128.mem_rdata;
                break;
            end
        end
        if (l < 0) begin
            checks++; errors++;
            $display("FAIL ack_timeout addr=%h got=none exp=ack", a);
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        req = 0;
    endtask

    function automatic logic [127:0] pat(input int a);
        logic [31:0] v;
        v = 32'(a);
        return {v * 32'h9E3779B1, v ^ 32'hA5A5A5A5, (v << 5) | 32'h7, v + 32'h1000};
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req = 0; we = 0; addr = '0; wdata = '0;
        scan_active = 0; scan_en = 0; scan_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        run = 1;
        chk("reset_rdata64", {64'b0, m64.mem_rdata}, 0);
        chk("reset_rdata128", m128.mem_rdata, 0);
        chk("reset_scan64", {64'b0, scan_rdata64}, 0);
        chk("reset_scan128", scan_rdata128, 0);
        @(posedge clk); #1 rst = 0;

        // 1: idle scan; the write and the read each complete one cycle after req
        host_access(1, 11'h0AA, 128'hDEADBEEF, 0, lat, r64, r128);
        chk("t1_wr_lat", lat, 1);
        host_access(0, 11'h0AA, '0, 0, lat, r64, r128);
        chk("t1_rd_lat", lat, 1);
        chk("t1_rd64", r64, 128'hDEADBEEF);
        chk("t1_rd128", r128, 128'hDEADBEEF);

        // 2: a write in a frame is stalled; scans during the frame see the old value
        host_access(1, 11'h010, 128'hCAFEF00D, 0, lat, r64, r128);
        @(posedge clk); #1 scan_active = 1;
        fork
            host_access(1, 11'h010, 128'h12345678, 0, lat, r64, r128);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    scan_en = (i % 2 == 0); scan_addr = 11'h010;
                    if (i % 2 == 1) begin
                        @(negedge clk);
                        chk("t2_scan_old", scan_rdata128, 128'hCAFEF00D);
                        chk("t2_pend", {127'b0, pend128}, 1);
                    end
                end
                @(posedge clk); #1 scan_active = 0; scan_en = 0;
            end
        join
        chk("t2_lat", lat, 7);
        @(posedge clk); #1 scan_en = 1; scan_addr = 11'h010;
        @(posedge clk); #1 scan_en = 0;
        @(negedge clk);
        chk("t2_scan_new", scan_rdata128, 128'h12345678);

        // a scan on the cycle after the write returns the new data
        fork
            host_access(1, 11'h020, 128'hA5A5_0F0F_0000_1111_2222_3333_4444_5555, 0, lat, r64, r128);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1 scan_en = 1; scan_addr = 11'h020;
                @(posedge clk); #1 scan_en = 0;
                @(negedge clk);
                chk("wf_scan128", scan_rdata128, 128'hA5A5_0F0F_0000_1111_2222_3333_4444_5555);
                chk("wf_scan64", {64'b0, scan_rdata64}, 128'h2222_3333_4444_5555);
            end
        join

        // 3: five cycles of scan hold off a host read
        fork
            host_access(0, 11'h0AA, '0, 0, lat, r64, r128);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    scan_en = 1; scan_addr = (i % 2 == 0) ? 11'h0AA : 11'h010;
                    if (i == 1) begin
                        @(negedge clk);
                        chk("t3_scan", scan_rdata128, 128'hDEADBEEF);
                    end
                end
                @(posedge clk); #1 scan_en = 0;
            end
        join
        chk("t3_lat", lat, 6);
        chk("t3_rd128", r128, 128'hDEADBEEF);

        // 4: req held for 3 cycles after ack gives a single access
        c0 = ack_cnt;
        host_access(0, 11'h0AA, '0, 3, lat, r64, r128);
        chk("t4_one_ack", ack_cnt - c0, 1);
        host_access(0, 11'h010, '0, 0, lat, r64, r128);
        chk("t4_next_lat", lat, 1);
        chk("t4_next_rd", r128, 128'h12345678);
        chk("t4_acks", ack_cnt - c0, 2);

        // 5a: reset during RESP drops the ack; the write had already landed
        c0 = ack_cnt;
        @(posedge clk); #1 req = 1; we = 1; addr = 11'h030; wdata = 128'h11111111;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("t5_resp_ack128", {127'b0, m128.mem_ack}, 0);
        chk("t5_resp_ack64", {127'b0, m64.mem_ack}, 0);
        @(posedge clk); #1 rst = 0; req = 0;
        @(negedge clk);
        chk("t5_after_ack", {127'b0, m128.mem_ack}, 0);
        chk("t5_after_rdata", m128.mem_rdata, 0);
        chk("t5_no_ack", ack_cnt - c0, 0);
        host_access(0, 11'h030, '0, 0, lat, r64, r128);
        chk("t5_resp_data", r128, 128'h11111111);

        // 5b: reset in WAIT, on the very cycle the write would be granted
        host_access(1, 11'h040, 128'h33333333, 0, lat, r64, r128);
        @(posedge clk); #1 scan_active = 1; req = 1; we = 1; addr = 11'h040; wdata = 128'h22222222;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_wait_pend", {127'b0, pend128}, 1);
        @(posedge clk); #1 scan_active = 0; rst = 1;
        @(negedge clk);
        chk("t5_rst_pend", {127'b0, pend128}, 0);
        @(posedge clk); #1 rst = 0; req = 0;
        @(negedge clk);
        chk("t5_idle_pend", {127'b0, pend64}, 0);
        host_access(0, 11'h040, '0, 0, lat, r64, r128);
        chk("t5_no_write", r128, 128'h33333333);

        // req dropped while waiting: no access, no ack
        host_access(1, 11'h050, 128'h55555555, 0, lat, r64, r128);
        c0 = ack_cnt;
        @(posedge clk); #1 scan_active = 1; req = 1; we = 1; addr = 11'h050; wdata = 128'h44444444;
        @(posedge clk); #1;
        @(posedge clk); #1 req = 0;
        @(posedge clk); #1 scan_active = 0;
        repeat (3) @(negedge clk);
        chk("drop_no_ack", ack_cnt - c0, 0);
        host_access(0, 11'h050, '0, 0, lat, r64, r128);
        chk("drop_data", r128, 128'h55555555);

        // 6: full-depth sweep starting at 0x7FF then wrapping to 0x000
        for (int i = 0; i < 2048; i++)
            host_access(1, AW'((i + 2047) % 2048), pat((i + 2047) % 2048), 0, lat, r64, r128);
        for (int i = 0; i < 2048; i++) begin
            logic [127:0] p;
            p = pat((i + 2047) % 2048);
            host_access(0, AW'((i + 2047) % 2048), '0, 0, lat, r64, r128);
            chk("sweep128", r128, p);
            chk("sweep64", r64, {64'b0, p[63:0]});
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
